// File: rtl/washer_sequencer.sv
// washer_sequencer: executes the wash program fetched from ROM; owns the loop counters,
// the tick-based duration timer and the registered actuators. Optional `WASHER_PAUSE_EN adds a pause input.
module washer_sequencer #(
  parameter int INSTRS_WIDTH = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_REGS     = 4,
  parameter int START_ADDR   = 2,
  parameter int TICK_DIV     = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef WASHER_PAUSE_EN
  input  logic                    pause,
`endif
  output logic [ADDR_WIDTH-1:0]   pc,
  input  logic [INSTRS_WIDTH-1:0] instr,
  output logic                    fill,
  output logic                    drain,
  output logic                    motor_fwd,
  output logic                    motor_rev,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]         PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] START_PC  = ADDR_WIDTH'(START_ADDR);

  localparam logic [7:0] OP_HALT = 8'h00, OP_WAIT = 8'h01, OP_FILL = 8'h02, OP_REL = 8'h03;
  localparam logic [7:0] OP_FWD  = 8'h04, OP_REV  = 8'h05, OP_SET  = 8'h11, OP_DEC = 8'h12;
  localparam logic [7:0] OP_J    = 8'h20, OP_JZ   = 8'h21, OP_JNZ  = 8'h22;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TIMED, S_HALT} state_t;

  state_t                r_state, w_stateNext;
  logic [ADDR_WIDTH-1:0] r_pc, w_pcNext, w_pcInc, w_target;
  logic [15:0]           r_regs [NUM_REGS];
  logic [15:0]           w_regsNext [NUM_REGS];
  logic [15:0]           r_timer, w_timerNext;
  logic [PW-1:0]         r_presc, w_prescNext;
  logic [3:0]            r_mask, w_maskNext, r_act, w_actNext, w_opMask;
  logic                  r_done, w_doneNext, r_error, w_errorNext, w_paused;
  logic [7:0]            w_op, w_rsel;
  logic [15:0]           w_imm, w_regVal;
  logic [RW-1:0]         w_idx;

  assign w_op     = instr[7:0];
  assign w_rsel   = instr[15:8];
  assign w_imm    = instr[31:16];
  assign w_idx    = RW'(32'(w_rsel) % NUM_REGS);
  assign w_regVal = r_regs[w_idx];
  assign w_target = w_imm[ADDR_WIDTH-1:0];
  assign w_pcInc  = r_pc + ADDR_WIDTH'(1);

`ifdef WASHER_PAUSE_EN
  assign w_paused = pause;
`else
  assign w_paused = 1'b0;
`endif

  // Actuator bit order is {motor_rev, motor_fwd, drain, fill}; one-hot keeps fwd/rev exclusive.
  always_comb begin
    w_opMask = 4'b0000;
    case (w_op)
      OP_FILL: w_opMask = 4'b0001;
      OP_REL:  w_opMask = 4'b0010;
      OP_FWD:  w_opMask = 4'b0100;
      OP_REV:  w_opMask = 4'b1000;
      default: w_opMask = 4'b0000;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_regsNext  = r_regs;
    w_timerNext = r_timer;
    w_prescNext = r_presc;
    w_maskNext  = r_mask;
    w_actNext   = 4'b0000;
    w_doneNext  = r_done;
    w_errorNext = r_error;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_stateNext = S_RUN;
          w_pcNext    = START_PC;
          w_doneNext  = 1'b0;
          w_errorNext = 1'b0;
          for (int i = 0; i < NUM_REGS; i++) w_regsNext[i] = '0;
        end
      end
      S_RUN: begin
        case (w_op)
          OP_HALT: begin
            w_stateNext = S_HALT;
            w_doneNext  = 1'b1;
          end
          OP_WAIT, OP_FILL, OP_REL, OP_FWD, OP_REV: begin
            if (w_imm == 16'd0) begin
              w_pcNext = w_pcInc;
            end else begin
              w_timerNext = w_imm;
              w_prescNext = '0;
              w_maskNext  = w_opMask;
              w_actNext   = w_opMask;
              w_stateNext = S_TIMED;
            end
          end
          OP_SET: begin
            w_regsNext[w_idx] = w_imm;
            w_pcNext          = w_pcInc;
          end
          OP_DEC: begin
            if (w_regVal != 16'd0) w_regsNext[w_idx] = w_regVal - 16'd1;
            w_pcNext = w_pcInc;
          end
          OP_J:   w_pcNext = w_target;
          OP_JZ:  w_pcNext = (w_regVal == 16'd0) ? w_target : w_pcInc;
          OP_JNZ: w_pcNext = (w_regVal != 16'd0) ? w_target : w_pcInc;
          default: begin
            w_stateNext = S_HALT;
            w_errorNext = 1'b1;
          end
        endcase
      end
      S_TIMED: begin
        // A paused op keeps its counters and drops the actuator until released.
        if (!w_paused) begin
          w_actNext = r_mask;
          if (r_presc == PRESC_MAX) begin
            w_prescNext = '0;
            if (r_timer == 16'd1) begin
              w_actNext   = 4'b0000;
              w_pcNext    = w_pcInc;
              w_stateNext = S_RUN;
            end else begin
              w_timerNext = r_timer - 16'd1;
            end
          end else begin
            w_prescNext = r_presc + PW'(1);
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_timer <= '0;
      r_presc <= '0;
      r_mask  <= '0;
      r_act   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      r_regs  <= w_regsNext;
      r_timer <= w_timerNext;
      r_presc <= w_prescNext;
      r_mask  <= w_maskNext;
      r_act   <= w_actNext;
      r_done  <= w_doneNext;
      r_error <= w_errorNext;
    end
  end

  assign pc        = r_pc;
  assign fill      = r_act[0];
  assign drain     = r_act[1];
  assign motor_fwd = r_act[2];
  assign motor_rev = r_act[3];
  assign done      = r_done;
  assign error     = r_error;
  assign busy      = (r_state == S_RUN) || (r_state == S_TIMED);

endmodule

// File: tb/tb_washer_sequencer.sv
// tb_washer_sequencer: table vectors, hand-written corner sequences and random programs
// checked against an instruction-level trace model; define WASHER_PAUSE_EN to exercise pause.
module tb_washer_sequencer;

  localparam int TD = 2;

  logic        clk = 1'b0;
  logic        rst, start;
`ifdef WASHER_PAUSE_EN
  logic        pause;
`endif
  logic [7:0]  pc;
  logic [31:0] instr;
  logic        fill, drain, motor_fwd, motor_rev, busy, done, error;
  logic [3:0]  actBus;
  logic [31:0] rom [256];

  int total = 0;
  int bad   = 0;
  int actCnt [4];
  int winCnt [4];
  int runCycles;
  bit overlap;

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] act;
    logic       busy;
    logic       done;
    logic       error;
  } snap_t;
  snap_t expQ [$];

  typedef struct {
    logic [7:0]  setSel;
    logic [15:0] preset;
    logic [7:0]  op;
    logic [7:0]  rsel;
    logic [15:0] imm;
    logic [7:0]  expPc;
    logic        expDone;
    logic        expError;
    logic [3:0]  expMask;
    int          expCyc;
  } vec_t;
  vec_t vecs [$];

  assign instr  = rom[pc];
  assign actBus = {motor_rev, motor_fwd, drain, fill};

  always #5 clk = ~clk;

  washer_sequencer #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef WASHER_PAUSE_EN
    .pause     (pause),
`endif
    .pc        (pc),
    .instr     (instr),
    .fill      (fill),
    .drain     (drain),
    .motor_fwd (motor_fwd),
    .motor_rev (motor_rev),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] rsel, input logic [15:0] imm);
    return {imm, rsel, op};
  endfunction

  function automatic logic [3:0] timedMask(input logic [7:0] op);
    return (op == 8'h01) ? 4'b0000 : (4'b0001 << (op - 8'd2));
  endfunction

  function automatic snap_t snap(input logic [7:0] p, input logic [3:0] a, input logic b, input logic d, input logic e);
    snap_t s;
    s.pc = p; s.act = a; s.busy = b; s.done = d; s.error = e;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
  endtask

  task automatic runUntilIdle(input int budget);
    logic [3:0] prev;
    prev      = actBus;
    runCycles = 0;
    overlap   = 1'b0;
    for (int b = 0; b < 4; b++) begin actCnt[b] = 0; winCnt[b] = 0; end
    while (busy && runCycles < budget) begin
      cycle();
      runCycles++;
      for (int b = 0; b < 4; b++) begin
        if (actBus[b]) actCnt[b]++;
        if (actBus[b] && !prev[b]) winCnt[b]++;
      end
      if (motor_fwd && motor_rev) overlap = 1'b1;
      prev = actBus;
    end
    checkOutput("run reaches idle within budget", busy, 0);
  endtask

  // Instruction-level interpreter: emits the expected sample seen after every clock edge.
  task automatic modelRun();
    logic [7:0]  p;
    logic [15:0] regs [4];
    logic [31:0] ins;
    logic [7:0]  op;
    logic [15:0] imm;
    int          idx, n;
    bit          stop;
    p = 8'd2;
    for (int i = 0; i < 4; i++) regs[i] = 16'd0;
    stop = 1'b0;
    expQ.delete();
    expQ.push_back(snap(p, 4'b0, 1'b1, 1'b0, 1'b0));
    while (!stop && expQ.size() < 3000) begin
      ins = rom[p];
      op  = ins[7:0];
      idx = int'(ins[15:8]) % 4;
      imm = ins[31:16];
      case (op)
        8'h00: begin expQ.push_back(snap(p, 4'b0, 1'b0, 1'b1, 1'b0)); stop = 1'b1; end
        8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
          n = int'(imm) * TD;
          for (int k = 0; k < n; k++) expQ.push_back(snap(p, timedMask(op), 1'b1, 1'b0, 1'b0));
          p = p + 8'd1;
          expQ.push_back(snap(p, 4'b0, 1'b1, 1'b0, 1'b0));
        end
        8'h11: begin regs[idx] = imm; p = p + 8'd1; expQ.push_back(snap(p, 4'b0, 1'b1, 1'b0, 1'b0)); end
        8'h12: begin
          if (regs[idx] > 0) regs[idx] = regs[idx] - 16'd1;
          p = p + 8'd1;
          expQ.push_back(snap(p, 4'b0, 1'b1, 1'b0, 1'b0));
        end
        8'h20, 8'h21, 8'h22: begin
          if (op == 8'h20 || (op == 8'h21 && regs[idx] == 0) || (op == 8'h22 && regs[idx] != 0)) p = imm[7:0];
          else p = p + 8'd1;
          expQ.push_back(snap(p, 4'b0, 1'b1, 1'b0, 1'b0));
        end
        default: begin expQ.push_back(snap(p, 4'b0, 1'b0, 1'b0, 1'b1)); stop = 1'b1; end
      endcase
    end
    repeat (2) expQ.push_back(expQ[$]);
  endtask

  task automatic genProgram();
    logic [7:0] illegalOps [6];
    logic [7:0] a, tgt;
    int         len, kind;
    illegalOps = '{8'h06, 8'h10, 8'h13, 8'h23, 8'h7F, 8'hFF};
    clearRom();
    len = $urandom_range(4, 16);
    for (int i = 0; i < len; i++) begin
      a    = 8'(2 + i);
      kind = $urandom_range(0, 19);
      tgt  = 8'($urandom_range(3 + i, 2 + len));
      if (kind < 4)        rom[a] = mk(8'h11, 8'($urandom), 16'($urandom_range(0, 2)));
      else if (kind < 6)   rom[a] = mk(8'h12, 8'($urandom), 16'($urandom));
      else if (kind < 8)   rom[a] = mk(8'h21, 8'($urandom), {8'($urandom), tgt});
      else if (kind < 10)  rom[a] = mk(8'h22, 8'($urandom), {8'($urandom), tgt});
      else if (kind == 10) rom[a] = mk(8'h20, 8'($urandom), {8'($urandom), tgt});
      else if (kind < 18)  rom[a] = mk(8'($urandom_range(1, 5)), 8'($urandom), 16'($urandom_range(0, 3)));
      else if (kind == 18) rom[a] = 32'd0;
      else                 rom[a] = mk(illegalOps[$urandom_range(0, 5)], 8'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
`ifdef WASHER_PAUSE_EN
    pause = 1'b0;
`endif
    clearRom();
    repeat (2) cycle();
    checkOutput("reset pc", pc, 2);
    checkOutput("reset actuators", actBus, 0);
    checkOutput("reset busy/done/error", {busy, done, error}, 0);
    rst = 1'b0;
    cycle();
    checkOutput("idle without start", {busy, done, error, actBus}, 0);

    // fill 3 ticks then halt
    rom[2] = mk(8'h02, 8'd0, 16'd3);
    rom[3] = 32'd0;
    applyStimulus();
    checkOutput("fill: pc after start", pc, 2);
    runUntilIdle(200);
    checkOutput("fill: high clks", actCnt[0], 6);
    checkOutput("fill: windows", winCnt[0], 1);
    checkOutput("fill: final pc", pc, 3);
    checkOutput("fill: done/error", {done, error}, 2'b10);

    // counted loop of forward pulses
    clearRom();
    rom[2] = mk(8'h11, 8'd0, 16'd2);
    rom[3] = mk(8'h04, 8'd0, 16'd1);
    rom[4] = mk(8'h12, 8'd0, 16'd0);
    rom[5] = mk(8'h22, 8'd0, 16'd3);
    rom[6] = mk(8'h21, 8'd0, 16'd10);
    applyStimulus();
    runUntilIdle(200);
    checkOutput("loop: fwd windows", winCnt[2], 2);
    checkOutput("loop: fwd high clks", actCnt[2], 4);
    checkOutput("loop: r0 reached 0 (pc)", pc, 10);
    checkOutput("loop: fwd/rev exclusive", overlap, 0);

    // dec saturation then jz
    clearRom();
    rom[2] = mk(8'h12, 8'd1, 16'd0);
    rom[3] = mk(8'h21, 8'd1, 16'd40);
    applyStimulus();
    runUntilIdle(50);
    checkOutput("dec saturates: pc", pc, 40);

    vecs.push_back('{8'd0, 16'd0, 8'h00, 8'd0, 16'd0,      8'd3,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd2, 16'd9, 8'h11, 8'd2, 16'd7,      8'd4,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd1, 16'd0, 8'h12, 8'd1, 16'd0,      8'd4,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd1, 16'd0, 8'h21, 8'd1, 16'd40,     8'd40, 1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd1, 16'd5, 8'h21, 8'd1, 16'd40,     8'd4,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd3, 16'd5, 8'h22, 8'd3, 16'h1234,   8'h34, 1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd0, 16'd0, 8'h22, 8'd0, 16'd50,     8'd4,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd0, 16'd0, 8'h20, 8'd0, 16'h0105,   8'd5,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd5, 16'd3, 8'h22, 8'd1, 16'd60,     8'd60, 1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd6, 16'd4, 8'h21, 8'd2, 16'd70,     8'd4,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd0, 16'd0, 8'h02, 8'd0, 16'd3,      8'd4,  1'b1, 1'b0, 4'b0001, 6});
    vecs.push_back('{8'd0, 16'd0, 8'h03, 8'd0, 16'd1,      8'd4,  1'b1, 1'b0, 4'b0010, 2});
    vecs.push_back('{8'd0, 16'd0, 8'h04, 8'd0, 16'd0,      8'd4,  1'b1, 1'b0, 4'b0100, 0});
    vecs.push_back('{8'd0, 16'd0, 8'h05, 8'd0, 16'd2,      8'd4,  1'b1, 1'b0, 4'b1000, 4});
    vecs.push_back('{8'd0, 16'd0, 8'h01, 8'd0, 16'd2,      8'd4,  1'b1, 1'b0, 4'b0000, 0});
    vecs.push_back('{8'd0, 16'd0, 8'h7F, 8'd0, 16'd0,      8'd3,  1'b0, 1'b1, 4'b0000, 0});
    vecs.push_back('{8'd0, 16'd0, 8'h13, 8'd0, 16'd0,      8'd3,  1'b0, 1'b1, 4'b0000, 0});
    for (int v = 0; v < vecs.size(); v++) begin
      clearRom();
      rom[2] = mk(8'h11, vecs[v].setSel, vecs[v].preset);
      rom[3] = mk(vecs[v].op, vecs[v].rsel, vecs[v].imm);
      applyStimulus();
      runUntilIdle(100);
      checkOutput($sformatf("vec%0d pc", v), pc, vecs[v].expPc);
      checkOutput($sformatf("vec%0d done/error", v), {done, error}, {vecs[v].expDone, vecs[v].expError});
      for (int b = 0; b < 4; b++)
        checkOutput($sformatf("vec%0d act%0d clks", v, b), actCnt[b], vecs[v].expMask[b] ? vecs[v].expCyc : 0);
    end

    // pc wraps 255 -> 0
    clearRom();
    rom[2]   = mk(8'h20, 8'd0, 16'd255);
    rom[255] = mk(8'h11, 8'd0, 16'd1);
    applyStimulus();
    runUntilIdle(50);
    checkOutput("wrap: pc", pc, 0);
    checkOutput("wrap: done", done, 1);

    // illegal opcode then restart
    clearRom();
    rom[2] = mk(8'h20, 8'd0, 16'd9);
    rom[9] = mk(8'h7F, 8'd0, 16'd0);
    applyStimulus();
    runUntilIdle(50);
    checkOutput("illegal: pc", pc, 9);
    checkOutput("illegal: done/error", {done, error}, 2'b01);
    checkOutput("illegal: actuators", actBus, 0);
    applyStimulus();
    checkOutput("restart: pc", pc, 2);
    checkOutput("restart: error/busy", {error, busy}, 2'b01);
    runUntilIdle(50);

    for (int prog = 0; prog < 20; prog++) begin
      genProgram();
      modelRun();
      applyStimulus();
      checkOutput($sformatf("rand%0d cyc0", prog), pc == expQ[0].pc && actBus == expQ[0].act &&
                  busy == expQ[0].busy && done == expQ[0].done && error == expQ[0].error, 1);
      for (int k = 1; k < expQ.size(); k++) begin
        start = expQ[k-1].busy && ($urandom_range(0, 3) == 0);
        cycle();
        checkOutput($sformatf("rand%0d cyc%0d", prog, k), {pc, actBus, busy, done, error}, expQ[k]);
      end
      start = 1'b0;
    end

`ifdef WASHER_PAUSE_EN
    begin
      int fillHigh;
      clearRom();
      rom[2] = mk(8'h02, 8'd0, 16'd4);
      applyStimulus();
      fillHigh = 0;
      repeat (3) begin cycle(); if (fill) fillHigh++; end
      pause = 1'b1;
      repeat (5) begin
        cycle();
        checkOutput("pause: fill low", fill, 0);
        checkOutput("pause: still busy", busy, 1);
      end
      pause = 1'b0;
      runUntilIdle(100);
      checkOutput("pause: total fill clks", fillHigh + actCnt[0], 8);
      checkOutput("pause: final pc", pc, 3);
    end
`endif

    // asynchronous reset in the middle of a long reverse
    clearRom();
    rom[2] = mk(8'h05, 8'd0, 16'd100);
    applyStimulus();
    repeat (3) cycle();
    checkOutput("rev: motor_rev on", motor_rev, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    checkOutput("rev: start ignored pc", pc, 2);
    checkOutput("rev: start ignored busy/rev", {busy, motor_rev}, 2'b11);
    #1 rst = 1'b1;
    #1;
    checkOutput("async rst: motor_rev", motor_rev, 0);
    checkOutput("async rst: pc", pc, 2);
    checkOutput("async rst: busy", busy, 0);
    #1 rst = 1'b0;
    cycle();
    checkOutput("after rst: idle", {busy, done, error, actBus}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
